// File: rtl/cpu8_memctrl_if.sv
// CPU-side access bus of the 8-bit memory controller: request/write/addr/data
// travelling to the controller, ack/read data travelling back.
interface cpu8_memctrl_if #(
  parameter int ADDR_BITS = 8,
  parameter int WORD_BITS = 8
);
  logic                 in_cpu_req;
  logic                 in_cpu_write;
  logic [ADDR_BITS-1:0] in_cpu_addr;
  logic [WORD_BITS-1:0] in_cpu_data;
  logic                 out_cpu_ack;
  logic [WORD_BITS-1:0] out_cpu_data;

  modport master (
    output in_cpu_req, in_cpu_write, in_cpu_addr, in_cpu_data,
    input  out_cpu_ack, out_cpu_data
  );

  modport slave (
    input  in_cpu_req, in_cpu_write, in_cpu_addr, in_cpu_data,
    output out_cpu_ack, out_cpu_data
  );
endinterface

// File: rtl/cpu8_memctrl.sv
// Wait-stated RAM/I-O controller for an 8-bit CPU with a program loader port.
// The all-ones address is the I/O window (out_port on write, synchronised in_port on read).
module cpu8_memctrl #(
  parameter int ADDR_BITS   = 8,
  parameter int WORD_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  cpu8_memctrl_if.slave        cpu,
  input  logic                 in_load_en,
  input  logic [ADDR_BITS-1:0] in_load_addr,
  input  logic [WORD_BITS-1:0] in_load_data,
  input  logic [WORD_BITS-1:0] in_port,
  output logic [WORD_BITS-1:0] out_port,
  output logic                 out_busy
);
  localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [ADDR_BITS-1:0] IO_ADDR = '1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 pend, pend_nxt;
  logic                 pend_wr, pend_wr_nxt;
  logic                 accept, access;

  logic [ADDR_BITS-1:0] addr_q;
  logic                 wr_q;
  logic [WORD_BITS-1:0] wdata_q;
  logic [WORD_BITS-1:0] sync1, sync2;

  logic [WORD_BITS-1:0] ram [2**ADDR_BITS];
  logic [WORD_BITS-1:0] ram_q;
  logic                 ram_we;
  logic [ADDR_BITS-1:0] ram_wa, rd_addr;
  logic [WORD_BITS-1:0] ram_wd;

  // FSM state register
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pend    <= 1'b0;
      pend_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend    <= pend_nxt;
      pend_wr <= pend_wr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pend_nxt    = pend;
    pend_wr_nxt = pend_wr;
    accept      = 1'b0;
    access      = 1'b0;
    case (state)
      IDLE: begin
        if (in_load_en) begin
          // Loader owns the cycle; remember a colliding CPU pulse for later.
          if (cpu.in_cpu_req) begin
            pend_nxt    = 1'b1;
            pend_wr_nxt = cpu.in_cpu_write;
          end
        end else if (cpu.in_cpu_req || pend) begin
          accept    = 1'b1;
          cnt_nxt   = CNT_W'(WAIT_STATES);
          pend_nxt  = 1'b0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          access    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out_busy = (state != IDLE);

  // Datapath: latched request, ack, read data, I/O port and in_port synchroniser
  always_ff @(posedge in_clk) begin
    if (!in_rst) begin
      addr_q           <= '0;
      wr_q             <= 1'b0;
      wdata_q          <= '0;
      cpu.out_cpu_ack  <= 1'b0;
      cpu.out_cpu_data <= '0;
      out_port         <= '0;
      sync1            <= '0;
      sync2            <= '0;
    end else begin
      sync1           <= in_port;
      sync2           <= sync1;
      cpu.out_cpu_ack <= access;
      if (accept) begin
        addr_q  <= cpu.in_cpu_addr;
        wr_q    <= cpu.in_cpu_req ? cpu.in_cpu_write : pend_wr;
        wdata_q <= cpu.in_cpu_data;
      end
      if (access) begin
        if (wr_q) begin
          if (addr_q == IO_ADDR) out_port <= wdata_q;
        end else begin
          cpu.out_cpu_data <= (addr_q == IO_ADDR) ? sync2 : ram_q;
        end
      end
    end
  end

  // Read address follows the live CPU address in IDLE so the data is ready
  // even with zero wait states; the array itself is never reset.
  assign rd_addr = (state == IDLE) ? cpu.in_cpu_addr : addr_q;
  assign ram_we  = in_rst &&
                   ((state == IDLE && in_load_en && in_load_addr != IO_ADDR) ||
                    (access && wr_q && addr_q != IO_ADDR));
  assign ram_wa  = access ? addr_q : in_load_addr;
  assign ram_wd  = access ? wdata_q : in_load_data;

  always_ff @(posedge in_clk) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    ram_q <= ram[rd_addr];
  end
endmodule

// File: tb/tb_cpu8_memctrl.sv
// Randomised self-checking bench for cpu8_memctrl: a WAIT_STATES=2 instance and a
// WAIT_STATES=0 instance share loader/in_port, each checked against an array model.
module tb_cpu8_memctrl;
  logic       in_clk = 1'b0;
  logic       in_rst;
  logic       load_en;
  logic [7:0] load_addr, load_data, in_port;
  logic [7:0] port2, port0;
  logic       busy2, busy0;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem2 [256];
  logic [7:0] mem0 [256];
  logic [7:0] last2, last0;

  cpu8_memctrl_if #(.ADDR_BITS(8), .WORD_BITS(8)) b2 ();
  cpu8_memctrl_if #(.ADDR_BITS(8), .WORD_BITS(8)) b0 ();

  cpu8_memctrl #(.ADDR_BITS(8), .WORD_BITS(8), .WAIT_STATES(2)) dut2 (
    .in_clk(in_clk), .in_rst(in_rst), .cpu(b2),
    .in_load_en(load_en), .in_load_addr(load_addr), .in_load_data(load_data),
    .in_port(in_port), .out_port(port2), .out_busy(busy2)
  );

  cpu8_memctrl #(.ADDR_BITS(8), .WORD_BITS(8), .WAIT_STATES(0)) dut0 (
    .in_clk(in_clk), .in_rst(in_rst), .cpu(b0),
    .in_load_en(load_en), .in_load_addr(load_addr), .in_load_data(load_data),
    .in_port(in_port), .out_port(port0), .out_busy(busy0)
  );

  always #5 in_clk = ~in_clk;

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // sel = 1 selects the two-wait-state instance, 0 the zero-wait-state one
  function automatic logic ack_of(input bit sel);
    return sel ? b2.out_cpu_ack : b0.out_cpu_ack;
  endfunction
  function automatic logic busy_of(input bit sel);
    return sel ? busy2 : busy0;
  endfunction
  function automatic logic [7:0] data_of(input bit sel);
    return sel ? b2.out_cpu_data : b0.out_cpu_data;
  endfunction
  function automatic logic [7:0] port_of(input bit sel);
    return sel ? port2 : port0;
  endfunction

  task automatic drive(input bit sel, input bit req, input bit wr, input logic [7:0] a, d);
    if (sel) begin
      b2.in_cpu_req = req; b2.in_cpu_write = wr; b2.in_cpu_addr = a; b2.in_cpu_data = d;
    end else begin
      b0.in_cpu_req = req; b0.in_cpu_write = wr; b0.in_cpu_addr = a; b0.in_cpu_data = d;
    end
  endtask

  task automatic load(input logic [7:0] a, d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
    if (a != 8'hFF) begin
      mem2[a] = d;
      mem0[a] = d;
    end
  endtask

  // One CPU access from IDLE. lat = edges from acceptance to the ack edge.
  // Writes stay requested through the edge after ack; reads are a single pulse.
  task automatic op(input bit sel, input bit wr, input logic [7:0] a, d,
                    output logic [7:0] rd, output logic [7:0] port, output int lat,
                    output bit busy_bad, output bit post_bad);
    drive(sel, 1'b1, wr, a, d);
    busy_bad = 1'b0;
    tick();
    lat = 0;
    if (!wr) drive(sel, 1'b0, wr, a, d);
    while (!ack_of(sel) && lat < 20) begin
      if (!busy_of(sel)) busy_bad = 1'b1;
      tick();
      lat++;
    end
    if (!busy_of(sel)) busy_bad = 1'b1;
    rd   = data_of(sel);
    port = port_of(sel);
    tick();
    post_bad = ack_of(sel) || busy_of(sel);
    drive(sel, 1'b0, wr, a, d);
  endtask

  task automatic test_reset();
    in_rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 8'hFF, 8'hEE);
    drive(1'b0, 1'b1, 1'b1, 8'hFF, 8'hEE);
    tick(); tick();
    checks++; if (b2.out_cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", b2.out_cpu_ack); end
    checks++; if (b2.out_cpu_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", b2.out_cpu_data); end
    checks++; if (port2 !== 8'h00 || port0 !== 8'h00) begin errors++; $display("FAIL rst_port got %h/%h exp 00", port2, port0); end
    checks++; if (busy2 !== 1'b0 || busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b/%b exp 0", busy2, busy0); end
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    in_rst = 1'b1;
    tick();
    checks++; if (busy2 !== 1'b0 || b2.out_cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_release busy %b ack %b exp 0 0", busy2, b2.out_cpu_ack); end
    last2 = 8'h00; last0 = 8'h00;
  endtask

  task automatic test_load_read();
    logic [7:0] rd, pt; int lat; bit bb, pb;
    load(8'h10, 8'hA5);
    op(1'b1, 1'b0, 8'h10, 8'h00, rd, pt, lat, bb, pb);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_lat got %0d exp 3", lat); end
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL read_data got %h exp a5", rd); end
    checks++; if (bb || pb) begin errors++; $display("FAIL read_busy_window busy_bad %b post_bad %b exp 0 0", bb, pb); end
    last2 = 8'hA5;
  endtask

  task automatic test_write();
    logic [7:0] rd, pt; int lat; bit bb, pb;
    op(1'b1, 1'b1, 8'h20, 8'h3C, rd, pt, lat, bb, pb);
    mem2[8'h20] = 8'h3C;
    checks++; if (lat !== 3) begin errors++; $display("FAIL write_lat got %0d exp 3", lat); end
    checks++; if (pb) begin errors++; $display("FAIL write_single_ack post_bad %b exp 0", pb); end
    checks++; if (rd !== last2) begin errors++; $display("FAIL write_keeps_data got %h exp %h", rd, last2); end
    op(1'b1, 1'b0, 8'h20, 8'h00, rd, pt, lat, bb, pb);
    checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL write_readback got %h exp 3c", rd); end
    last2 = 8'h3C;
  endtask

  task automatic test_io();
    logic [7:0] rd, pt; int lat; bit bb, pb;
    op(1'b1, 1'b1, 8'hFF, 8'h81, rd, pt, lat, bb, pb);
    checks++; if (pt !== 8'h81) begin errors++; $display("FAIL io_out_port got %h exp 81", pt); end
    in_port = 8'h5A;
    repeat (3) tick();
    op(1'b1, 1'b0, 8'hFF, 8'h00, rd, pt, lat, bb, pb);
    checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL io_in_port got %h exp 5a", rd); end
    last2 = 8'h5A;
  endtask

  task automatic test_pending();
    int lat; bit seen;
    load_en = 1'b1; load_addr = 8'h40; load_data = 8'h99;
    drive(1'b1, 1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
    mem2[8'h40] = 8'h99; mem0[8'h40] = 8'h99;
    tick();
    checks++; if (b2.out_cpu_ack !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL pend_hold ack %b busy %b exp 0 0", b2.out_cpu_ack, busy2); end
    load_en = 1'b0;
    tick();
    lat = 0; seen = 1'b0;
    while (!b2.out_cpu_ack && lat < 20) begin
      if (!busy2) seen = 1'b1;
      tick();
      lat++;
    end
    checks++; if (lat !== 3) begin errors++; $display("FAIL pend_lat got %0d exp 3", lat); end
    checks++; if (b2.out_cpu_data !== 8'hA5) begin errors++; $display("FAIL pend_data got %h exp a5", b2.out_cpu_data); end
    checks++; if (seen) begin errors++; $display("FAIL pend_busy got idle during access exp busy"); end
    tick();
    last2 = 8'hA5;
  endtask

  task automatic test_reset_wait();
    logic [7:0] rd, pt; int lat; bit bb, pb, ack_seen;
    load(8'h30, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'h30, 8'h77);
    tick(); tick();
    in_rst = 1'b0;
    tick();
    checks++; if (b2.out_cpu_ack !== 1'b0 || busy2 !== 1'b0) begin errors++; $display("FAIL abort_state ack %b busy %b exp 0 0", b2.out_cpu_ack, busy2); end
    checks++; if (port2 !== 8'h00 || b2.out_cpu_data !== 8'h00) begin errors++; $display("FAIL abort_regs port %h data %h exp 00 00", port2, b2.out_cpu_data); end
    in_rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
    ack_seen = 1'b0;
    repeat (4) begin tick(); if (b2.out_cpu_ack) ack_seen = 1'b1; end
    checks++; if (ack_seen) begin errors++; $display("FAIL abort_no_ack got ack exp none"); end
    last2 = 8'h00; last0 = 8'h00;
    op(1'b1, 1'b0, 8'h30, 8'h00, rd, pt, lat, bb, pb);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL abort_ram got %h exp 00", rd); end
    op(1'b1, 1'b0, 8'h10, 8'h00, rd, pt, lat, bb, pb);
    checks++; if (rd !== 8'hA5) begin errors++; $display("FAIL ram_survives_reset got %h exp a5", rd); end
    last2 = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd, pt; int lat; bit bb, pb;
    for (int i = 0; i < 2; i++) begin
      op(1'b0, 1'b0, 8'(i), 8'h00, rd, pt, lat, bb, pb);
      checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_lat%0d got %0d exp 1", i, lat); end
      checks++; if (rd !== mem0[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, rd, mem0[i]); end
      last0 = mem0[i];
    end
  endtask

  task automatic test_random(input bit sel);
    logic [7:0] rd, pt, a, d, exp; int lat; bit bb, pb, wr; int exp_lat;
    exp_lat = sel ? 3 : 1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 3) == 0) load(8'($urandom), 8'($urandom));
      wr = (n == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom);
      d  = 8'($urandom);
      if (!wr && a == 8'hFF) begin
        in_port = 8'($urandom);
        repeat (3) tick();
      end
      op(sel, wr, a, d, rd, pt, lat, bb, pb);
      checks++; if (lat !== exp_lat || bb || pb) begin errors++; $display("FAIL rnd%0d_timing lat %0d bb %b pb %b exp %0d 0 0", sel, lat, bb, pb, exp_lat); end
      if (wr) begin
        exp = sel ? last2 : last0;
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd%0d_wr_data got %h exp %h", sel, rd, exp); end
        if (a == 8'hFF) begin
          checks++; if (pt !== d) begin errors++; $display("FAIL rnd%0d_port got %h exp %h", sel, pt, d); end
        end else if (sel) mem2[a] = d;
        else mem0[a] = d;
      end else begin
        exp = (a == 8'hFF) ? in_port : (sel ? mem2[a] : mem0[a]);
        checks++; if (rd !== exp) begin errors++; $display("FAIL rnd%0d_rd a %h got %h exp %h", sel, a, rd, exp); end
        if (sel) last2 = exp; else last0 = exp;
      end
    end
  endtask

  initial begin
    load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00; in_port = 8'h00;
    in_rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    test_reset();
    for (int i = 0; i < 255; i++) load(8'(i), 8'($urandom));
    test_load_read();
    test_write();
    test_io();
    test_pending();
    test_reset_wait();
    test_back_to_back();
    test_random(1'b1);
    test_random(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
